uart_tx_queue: RTL and testbench
================================

// Module: uart_tx_queue
// PURPOSE
//  Byte queue and start sequencer that sits directly upstream of the UART top level.
//  Accepts bytes from a valid/ready producer into a circular FIFO.
//  Presents one byte at a time on o_tx_data and raises o_tx_str for it.
//  Waits for the UART's tx-done before launching the next byte.
// PARAMETERS
//  DEPTH        16      FIFO entries; power of 2, >=2
//  TIMEOUT_CYC  200000  clk cycles allowed in SEND before abort (UART_TXQ_TIMEOUT_EN only)
// PORTS
//  clk         in   1               system clock, all logic on rising edge
//  rst         in   1               asynchronous, active-low reset
//  i_wr_valid  in   1               producer byte valid
//  i_wr_data   in   8               producer byte
//  o_wr_ready  out  1               FIFO can accept (count < DEPTH)
//  o_tx_data   out  8               byte to UART i_tx_data
//  o_tx_str    out  1               start request to UART i_tx_str
//  i_tx_done   in   1               UART o_tx_done (slower derived clock domain)
//  i_tx_er     in   1               UART o_tx_er
//  o_count     out  $clog2(DEPTH)+1 FIFO occupancy
//  o_busy      out  1               state != IDLE
//  o_err       out  2               sticky: [0] UART tx error, [1] timeout
//  i_err_clr   in   1               clear o_err
// BEHAVIOUR
//  Reset (rst=0, async):
//   - FIFO pointers=0, count=0; o_wr_ready=1; o_tx_data=0; o_tx_str=0; o_busy=0; o_err=0.
//   - Sync flops=0; state=IDLE.
//   - Mid-frame reset drops o_tx_str immediately and discards queue contents.
//  FIFO:
//   - Push when i_wr_valid & o_wr_ready; pop in LOAD only.
//   - Pointers wrap mod DEPTH.
//   - Push+pop in the same cycle: count unchanged, both pointers advance.
//   - Full: o_wr_ready=0 and writes are ignored. Count never exceeds DEPTH or goes below 0.
//  Done sync:
//   - i_tx_done and i_tx_er pass through 2-flop synchronizers.
//   - done_rise = sync_done & ~sync_done_d (third flop).
//  FSM:
//   - IDLE: count>0 -> LOAD.
//   - LOAD (1 cycle): o_tx_data <= FIFO[rd_ptr]; pop -> SEND.
//   - SEND: o_tx_str=1.
//       done_rise -> GAP, with o_err[0] |= sync_er sampled the same cycle.
//   - GAP: o_tx_str=0; wait until sync_done==0 -> IDLE.
//  Timing and data stability:
//   - o_tx_data is stable from LOAD+1 until the next LOAD.
//   - Latency: byte pushed at cycle N into an empty idle queue -> o_tx_str=1 at edge N+3
//     (count N+1, LOAD N+2, SEND N+3).
//   - A done_rise outside SEND is ignored.
//  o_err:
//   - Bits set sticky; cleared by i_err_clr.
//   - Set has priority over clear in the same cycle.
// CONFIGURATION
//  UART_TXQ_TIMEOUT_EN defined:
//   - 32-bit counter cleared on entry to SEND, increments each SEND cycle.
//   - Reaching TIMEOUT_CYC: o_tx_str=0, o_err[1]=1, state -> GAP; the byte is lost.
//  UART_TXQ_TIMEOUT_EN undefined:
//   - No counter; SEND waits indefinitely; o_err[1] tied 0.
// TESTING
//  - Reset: hold rst=0, 3 cycles -> o_wr_ready=1, o_count=0, o_tx_str=0, o_err=0.
//  - Single byte: push 0xA5 at cycle N -> o_tx_data=0xA5 and o_tx_str=1 at N+3.
//      Pulse done -> str falls 3 cycles after done; o_count=0.
//  - Fill: push 16 bytes 0x00..0x0F while done is held low -> o_wr_ready=0 at count 16.
//      17th push ignored. Model done -> bytes emitted 0x00..0x0F in order, none lost.
//  - Push+pop same cycle: count=5 and push coincides with LOAD -> count stays 5.
//  - Error: i_tx_er=1 with done pulse -> o_err=2'b01. i_err_clr -> 0.
//      i_err_clr coincident with a new error -> o_err stays 2'b01.
//  - Timeout (macro on, TIMEOUT_CYC=100): never pulse done -> str=0 after 100 SEND cycles.
//      o_err[1]=1; next byte then launches normally.

Source files
------------

// File: rtl/uart_tx_queue.sv
// Byte FIFO and start sequencer feeding a UART transmitter: one byte per o_tx_str, next launch after tx-done.
// Define UART_TXQ_TIMEOUT_EN to abort a SEND that waits TIMEOUT_CYC cycles for tx-done (sets o_err[1]).
module uart_tx_queue #(
    parameter int DEPTH       = 16,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_valid,
    input  logic [7:0]               i_wr_data,
    output logic                     o_wr_ready,
    output logic [7:0]               o_tx_data,
    output logic                     o_tx_str,
    input  logic                     i_tx_done,
    input  logic                     i_tx_er,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_busy,
    output logic [1:0]               o_err,
    input  logic                     i_err_clr
);
    localparam int AW = $clog2(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_param
            $error("uart_tx_queue: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_GAP} state_t;

    state_t        state_reg;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [7:0]    tx_data_reg;
    logic          tx_str_reg;
    logic [1:0]    err_reg, err_set;
    logic          done_s1_reg, done_s2_reg, done_s3_reg;
    logic          er_s1_reg, er_s2_reg;
    logic          push, pop, done_rise, tmo_hit;

    assign o_wr_ready = (count_reg != (AW + 1)'(DEPTH));
    assign push       = i_wr_valid & o_wr_ready;
    assign pop        = (state_reg == ST_LOAD);
    assign done_rise  = done_s2_reg & ~done_s3_reg;

    assign o_tx_data  = tx_data_reg;
    assign o_tx_str   = tx_str_reg;
    assign o_count    = count_reg;
    assign o_busy     = (state_reg != ST_IDLE);
    assign o_err      = err_reg;

`ifdef UART_TXQ_TIMEOUT_EN
    logic [31:0] tmo_cnt_reg;

    assign tmo_hit = (state_reg == ST_SEND) && (tmo_cnt_reg == 32'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == ST_LOAD) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == ST_SEND) begin
            tmo_cnt_reg <= tmo_cnt_reg + 32'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // A real tx-done wins over a simultaneous timeout, so the byte is not reported lost.
    always_comb begin
        err_set = 2'b00;
        if (state_reg == ST_SEND) begin
            if (done_rise)
                err_set[0] = er_s2_reg;
            else if (tmo_hit)
                err_set[1] = 1'b1;
        end
    end

    // Storage is left unreset so it maps onto block RAM; the pointers alone define contents.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= i_wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            tx_data_reg <= 8'h00;
            tx_str_reg  <= 1'b0;
            err_reg     <= 2'b00;
            done_s1_reg <= 1'b0;
            done_s2_reg <= 1'b0;
            done_s3_reg <= 1'b0;
            er_s1_reg   <= 1'b0;
            er_s2_reg   <= 1'b0;
        end else begin
            done_s1_reg <= i_tx_done;
            done_s2_reg <= done_s1_reg;
            done_s3_reg <= done_s2_reg;
            er_s1_reg   <= i_tx_er;
            er_s2_reg   <= er_s1_reg;

            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase

            err_reg <= (err_reg & ~{2{i_err_clr}}) | err_set;

            case (state_reg)
                ST_IDLE: begin
                    if (count_reg != '0)
                        state_reg <= ST_LOAD;
                end
                ST_LOAD: begin
                    tx_data_reg <= mem[rd_ptr_reg];
                    tx_str_reg  <= 1'b1;
                    state_reg   <= ST_SEND;
                end
                ST_SEND: begin
                    if (done_rise || tmo_hit) begin
                        tx_str_reg <= 1'b0;
                        state_reg  <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (!done_s2_reg)
                        state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue: expected bytes go into a scoreboard at push time and a
// monitor compares o_tx_data at every rising o_tx_str. Timeout test runs when UART_TXQ_TIMEOUT_EN is defined.
module tb_uart_tx_queue;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_wr_valid = 1'b0;
    logic [7:0] i_wr_data = 8'h00;
    logic       o_wr_ready;
    logic [7:0] o_tx_data;
    logic       o_tx_str;
    logic       i_tx_done = 1'b0;
    logic       i_tx_er = 1'b0;
    logic [4:0] o_count;
    logic       o_busy;
    logic [1:0] o_err;
    logic       i_err_clr = 1'b0;

    int         n_vec = 0;
    int         n_miss = 0;
    logic [7:0] sb [$];
    logic       str_prev = 1'b0;

    always #5 clk = ~clk;

    uart_tx_queue #(.DEPTH(16), .TIMEOUT_CYC(100)) dut (
        .clk(clk), .rst(rst),
        .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data), .o_wr_ready(o_wr_ready),
        .o_tx_data(o_tx_data), .o_tx_str(o_tx_str),
        .i_tx_done(i_tx_done), .i_tx_er(i_tx_er),
        .o_count(o_count), .o_busy(o_busy), .o_err(o_err), .i_err_clr(i_err_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d, input bit accept);
        i_wr_valid = 1'b1;
        i_wr_data  = d;
        if (accept)
            sb.push_back(d);
        step();
        i_wr_valid = 1'b0;
    endtask

    task automatic wait_str();
        for (int k = 0; k < 40 && !o_tx_str; k++)
            step();
        if (!o_tx_str)
            chk("str_wait_expired", {31'd0, o_tx_str}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40 && o_busy; k++)
            step();
        if (o_busy)
            chk("idle_wait_expired", {31'd0, o_busy}, 32'd0);
    endtask

    // UART model: 2-cycle done pulse; returns edges until o_tx_str was seen low.
    task automatic complete_byte(input logic er, input bit clr_at_set, output int lat);
        i_tx_done = 1'b1;
        i_tx_er   = er;
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            lat++;
            if (lat == 2) begin
                i_tx_done = 1'b0;
                i_tx_er   = 1'b0;
                if (clr_at_set)
                    i_err_clr = 1'b1;
            end
            if (lat == 3)
                i_err_clr = 1'b0;
            if (!o_tx_str)
                break;
        end
        i_tx_done = 1'b0;
        i_tx_er   = 1'b0;
        i_err_clr = 1'b0;
    endtask

    task automatic pulse_clr();
        i_err_clr = 1'b1;
        step();
        i_err_clr = 1'b0;
    endtask

    // Monitor: every launch must carry the oldest outstanding expected byte.
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                str_prev = 1'b0;
            end else begin
                if (o_tx_str && !str_prev) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL launch_unexpected: got data 0x%0h, expected no launch", o_tx_data);
                    end else begin
                        exp_b = sb.pop_front();
                        chk("launch_data", {24'd0, o_tx_data}, {24'd0, exp_b});
                    end
                end
                str_prev = o_tx_str;
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;

        // Reset
        repeat (3) step();
        chk("rst_wr_ready", {31'd0, o_wr_ready}, 32'd1);
        chk("rst_count", {27'd0, o_count}, 32'd0);
        chk("rst_tx_str", {31'd0, o_tx_str}, 32'd0);
        chk("rst_err", {30'd0, o_err}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_tx_data", {24'd0, o_tx_data}, 32'd0);
        rst = 1'b1;
        step();

        // Single byte: str at N+3, falls 3 cycles after done
        push_byte(8'hA5, 1'b1);
        step();
        chk("single_str_before_n3", {31'd0, o_tx_str}, 32'd0);
        step();
        chk("single_str_at_n3", {31'd0, o_tx_str}, 32'd1);
        chk("single_data_at_n3", {24'd0, o_tx_data}, 32'hA5);
        chk("single_count", {27'd0, o_count}, 32'd0);
        complete_byte(1'b0, 1'b0, lat);
        chk("done_to_str_fall", lat, 32'd3);
        wait_idle();
        chk("single_count_end", {27'd0, o_count}, 32'd0);

        // done/er while idle must be ignored
        i_tx_done = 1'b1;
        i_tx_er   = 1'b1;
        repeat (4) step();
        i_tx_done = 1'b0;
        i_tx_er   = 1'b0;
        repeat (4) step();
        chk("stray_done_busy", {31'd0, o_busy}, 32'd0);
        chk("stray_done_err", {30'd0, o_err}, 32'd0);

        // Fill: one byte parked in SEND, then 16 queued -> full
        push_byte(8'h5A, 1'b1);
        wait_str();
        for (int i = 0; i < 16; i++)
            push_byte(8'(i), 1'b1);
        chk("fill_count", {27'd0, o_count}, 32'd16);
        chk("fill_wr_ready", {31'd0, o_wr_ready}, 32'd0);
        push_byte(8'hEE, 1'b0);
        push_byte(8'hEF, 1'b0);
        chk("full_count_hold", {27'd0, o_count}, 32'd16);
        for (int i = 0; i < 17; i++) begin
            wait_str();
            complete_byte(1'b0, 1'b0, lat);
        end
        wait_idle();
        chk("fill_drained_count", {27'd0, o_count}, 32'd0);
        chk("fill_sb_empty", sb.size(), 32'd0);

        // Push coinciding with LOAD keeps count at 5
        push_byte(8'h30, 1'b1);
        wait_str();
        for (int i = 1; i <= 5; i++)
            push_byte(8'(8'h30 + i), 1'b1);
        chk("pp_count_before", {27'd0, o_count}, 32'd5);
        complete_byte(1'b0, 1'b0, lat);
        repeat (3) step();
        push_byte(8'h36, 1'b1);
        chk("pp_count_same", {27'd0, o_count}, 32'd5);
        chk("pp_str_relaunch", {31'd0, o_tx_str}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            wait_str();
            complete_byte(1'b0, 1'b0, lat);
        end
        wait_idle();

        // UART error, clear, and set-over-clear
        push_byte(8'h77, 1'b1);
        wait_str();
        complete_byte(1'b1, 1'b0, lat);
        chk("err_uart_set", {30'd0, o_err}, 32'd1);
        wait_idle();
        pulse_clr();
        chk("err_cleared", {30'd0, o_err}, 32'd0);
        push_byte(8'h78, 1'b1);
        wait_str();
        complete_byte(1'b1, 1'b1, lat);
        chk("err_set_over_clr", {30'd0, o_err}, 32'd1);
        wait_idle();
        pulse_clr();
        chk("err_cleared2", {30'd0, o_err}, 32'd0);

        // Mid-frame reset drops str at once and discards the queue
        push_byte(8'h40, 1'b1);
        push_byte(8'h41, 1'b1);
        push_byte(8'h42, 1'b1);
        wait_str();
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_str", {31'd0, o_tx_str}, 32'd0);
        chk("midrst_count", {27'd0, o_count}, 32'd0);
        sb.delete();
        step();
        rst = 1'b1;
        step();
        push_byte(8'h50, 1'b1);
        wait_str();
        chk("post_rst_data", {24'd0, o_tx_data}, 32'h50);
        complete_byte(1'b0, 1'b0, lat);
        wait_idle();

`ifdef UART_TXQ_TIMEOUT_EN
        // Timeout: str high for exactly 100 SEND cycles, then next byte launches normally
        push_byte(8'h99, 1'b1);
        wait_str();
        n = 0;
        for (int k = 0; k < 300 && o_tx_str; k++) begin
            step();
            n++;
        end
        chk("timeout_cycles", n, 32'd100);
        chk("timeout_err", {30'd0, o_err}, 32'd2);
        push_byte(8'h9A, 1'b1);
        wait_str();
        complete_byte(1'b0, 1'b0, lat);
        chk("after_timeout_lat", lat, 32'd3);
        wait_idle();
`else
        n = 0;
`endif

        chk("final_sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
